// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: MD_Op encoding, FSM states and the
// operation classification helpers used by this unit and by the decoder.
package mult_div_unit_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MADD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Operations that use the multiplier latency
  function automatic logic md_is_mult(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD);
  endfunction

  // Operations that use the divider latency
  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Single-cycle HI/LO writes
  function automatic logic md_is_move(input logic [MD_OP_W-1:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit. Owns HI/LO, computes the result in the
// issue cycle, then holds it in a pending register until the fixed latency
// has elapsed. Busy covers the issue cycle plus every RUN cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [MD_OP_W-1:0]   MD_Op,
  input  logic [31:0]          A,
  input  logic [31:0]          B,
  output logic                 Busy,
  output logic [31:0]          HI,
  output logic [31:0]          LO
);

  md_state_e   r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [63:0] r_pend, w_pend_next;
  logic [31:0] r_hi, r_lo, w_hi_next, w_lo_next;

  md_op_e      w_op;
  logic [3:0]  w_lat;
  logic [63:0] w_result;

  logic [63:0] w_a_sx, w_b_sx, w_prod_s, w_prod_u, w_madd;
  logic        w_b_zero;
  logic [31:0] w_b_safe, w_a_mag, w_b_mag, w_uq_s, w_ur_s, w_q_s, w_r_s, w_q_u, w_r_u;

  assign w_op  = md_op_e'(MD_Op);
  assign w_lat = md_is_div(MD_Op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // Multiplier: sign-extended operands give the signed product in the low 64 bits
  assign w_a_sx   = {{32{A[31]}}, A};
  assign w_b_sx   = {{32{B[31]}}, B};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_madd   = {r_hi, r_lo} + w_prod_s;

  // Divider: a zero divisor is replaced so the datapath never divides by 0;
  // the result is discarded in that case anyway. Signed division works on
  // magnitudes, which also makes 0x80000000 / -1 come out as 0x80000000 r 0.
  assign w_b_zero = (B == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : B;
  assign w_a_mag  = A[31] ? (~A + 32'd1) : A;
  assign w_b_mag  = w_b_safe[31] ? (~w_b_safe + 32'd1) : w_b_safe;
  assign w_uq_s   = w_a_mag / w_b_mag;
  assign w_ur_s   = w_a_mag % w_b_mag;
  assign w_q_s    = (A[31] ^ w_b_safe[31]) ? (~w_uq_s + 32'd1) : w_uq_s;
  assign w_r_s    = A[31] ? (~w_ur_s + 32'd1) : w_ur_s;
  assign w_q_u    = A / w_b_safe;
  assign w_r_u    = A % w_b_safe;

  // Result select as {hi, lo}; divide by zero re-commits the current HI/LO
  always_comb begin
    w_result = {r_hi, r_lo};
    case (w_op)
      MD_MULT:  w_result = w_prod_s;
      MD_MULTU: w_result = w_prod_u;
      MD_MADD:  w_result = w_madd;
      MD_DIV:   if (!w_b_zero) w_result = {w_r_s, w_q_s};
      MD_DIVU:  if (!w_b_zero) w_result = {w_r_u, w_q_u};
      default:  w_result = {r_hi, r_lo};
    endcase
  end

  // Next-state logic: r_cnt holds the RUN cycles still to go, commit on the last
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pend_next  = r_pend;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          if (md_is_mult(MD_Op) || md_is_div(MD_Op)) begin
            if (w_lat == 4'd1) begin
              {w_hi_next, w_lo_next} = w_result;
            end else begin
              w_pend_next  = w_result;
              w_cnt_next   = w_lat - 4'd1;
              w_state_next = ST_RUN;
            end
          end else if (md_is_move(MD_Op)) begin
            if (w_op == MD_MTHI) w_hi_next = A;
            else                 w_lo_next = A;
          end
        end
      end
      ST_RUN: begin
        if (r_cnt == 4'd1) begin
          {w_hi_next, w_lo_next} = r_pend;
          w_cnt_next   = 4'd0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and architectural registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
    end
  end

  assign Busy = Start | (r_state == ST_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a behavioural HI/LO model checked
// every cycle, directed cases with literal expectations, then random traffic.
module tb_mult_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MD_Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MD_Op(MD_Op),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;   // cycles of busy after the issue cycle still to go
  logic [63:0] m_res;
  int          m_lat;

  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd7: return {hi, lo} + 64'(sa * sb);
      3'd3: if (b == 32'd0) return {hi, lo};
            else return {32'(sa % sb), 32'(sa / sb)};
      3'd4: if (b == 32'd0) return {hi, lo};
            else return {a % b, a / b};
      default: return {hi, lo};
    endcase
  endfunction

  assign m_res = model_result(MD_Op, A, B, m_hi, m_lo);
  assign m_lat = (MD_Op == 3'd3 || MD_Op == 3'd4) ? DIV_CYCLES : MULT_CYCLES;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0; m_pend <= 64'd0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (Start) begin
      case (MD_Op)
        3'd0: ;
        3'd5: m_hi <= A;
        3'd6: m_lo <= A;
        default: begin
          if (m_lat == 1) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
          end else begin
            m_pend <= m_res;
            m_left <= m_lat - 1;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("busy", {31'd0, Busy}, {31'd0, (Start | (m_left > 0))});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  end

  // Issue one op, optionally inject a second Start at cycle inj_at, count Busy cycles
  task automatic issue_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int inj_at, input logic [2:0] inj_op, input logic [31:0] inj_a,
                           output int nbusy);
    Start = 1'b1; MD_Op = op; A = a; B = b;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!Busy) break;
      nbusy++;
      @(posedge clk); #1;
      if (k + 1 == inj_at) begin
        Start = 1'b1; MD_Op = inj_op; A = inj_a; B = $urandom;
      end else begin
        Start = 1'b0; MD_Op = 3'd0;
      end
    end
    if (Busy) check("busy_timeout", {31'd0, Busy}, 32'd0);
    Start = 1'b0; MD_Op = 3'd0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int nb;

  initial begin
    reset = 1'b1; Start = 1'b0; MD_Op = 3'd0; A = 32'd0; B = 32'd0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // MULT -2 * 3
    issue_run(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 32'd0, nb);
    check("mult_busy_cycles", nb, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // MULTU max * max
    issue_run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'd0, 32'd0, nb);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    // DIV / DIVU -7, 2
    issue_run(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0, nb);
    check("div_busy_cycles", nb, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    issue_run(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0, nb);
    check("divu_lo", LO, 32'h7FFF_FFFC);
    check("divu_hi", HI, 32'd1);

    // MTHI then MTLO on the very next cycle, then MADD
    issue_run(3'd5, 32'h1234_5678, 32'd0, 1, 3'd6, 32'd9, nb);
    check("move_busy_cycles", nb, 32'd2);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mtlo_lo", LO, 32'd9);
    issue_run(3'd7, 32'd2, 32'd3, 0, 3'd0, 32'd0, nb);
    check("madd_hi", HI, 32'h1234_5678);
    check("madd_lo", LO, 32'hF);

    // Divide by zero keeps HI/LO; Start during RUN is ignored
    issue_run(3'd5, 32'd5, 32'd0, 1, 3'd6, 32'd6, nb);
    issue_run(3'd3, 32'd77, 32'd0, 3, 3'd1, 32'd1234, nb);
    check("div0_busy_cycles", nb, 32'd10);
    check("div0_hi", HI, 32'd5);
    check("div0_lo", LO, 32'd6);
    issue_run(3'd4, 32'd77, 32'd0, 4, 3'd5, 32'hDEAD_BEEF, nb);
    check("mthi_in_run_hi", HI, 32'd5);

    // Signed overflow case
    issue_run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0, nb);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);

    // Reset in RUN cycle 2 aborts immediately
    Start = 1'b1; MD_Op = 3'd1; A = 32'd7; B = 32'd9;
    @(posedge clk); #1;
    Start = 1'b0; MD_Op = 3'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    issue_run(3'd1, 32'd4, 32'd4, 0, 3'd0, 32'd0, nb);
    check("post_rst_busy_cycles", nb, 32'd5);
    check("post_rst_lo", LO, 32'd16);
    check("post_rst_hi", HI, 32'd0);

    // Random traffic, including Starts while busy
    for (int i = 0; i < 1500; i++) begin
      Start = ($urandom_range(0, 3) == 0);
      MD_Op = 3'($urandom_range(0, 7));
      A = pick();
      B = pick();
      @(posedge clk); #1;
    end
    Start = 1'b0; MD_Op = 3'd0;
    repeat (DIV_CYCLES + 2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
